// File: rtl/sar10b_rx.sv
// rtl/sar10b_rx.sv - SAR 10-bit result receiver: CKO sync, capture, averaging, show-ahead FIFO
module sar10b_rx #(
  parameter int SYNC_STAGES = 2,
  parameter int FIFO_DEPTH  = 4,
  parameter int TIMEOUT     = 1023
) (
  input  logic                          CLK,
  input  logic                          RST_N,
  input  logic                          EN,
  input  logic                          CKO,
  input  logic [0:9]                    DATA,
  input  logic [1:0]                    AVG_SEL,
  input  logic                          CLR,
  output logic [9:0]                    OUT_DATA,
  output logic                          OUT_VALID,
  input  logic                          OUT_READY,
  output logic [$clog2(FIFO_DEPTH):0]   LEVEL,
  output logic                          OVF,
  output logic                          TMO
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [SYNC_STAGES-1:0] cko_sync;
  logic                   sync_d;
  logic                   edge_p;
  logic [9:0]             data_rev;
  logic                   cap_valid;
  logic [9:0]             cap_data;

  logic [2:0]  cnt;
  logic [1:0]  avg_lat;
  logic [12:0] acc;
  logic [1:0]  shift;
  logic [2:0]  last_cnt;
  logic [12:0] sum;
  logic        last;
  logic        push;
  logic [9:0]  avg_result;

  logic [9:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [LW-1:0] level;
  logic          full;
  logic          do_pop;
  logic          do_push;
  logic          ovf_evt;

  logic [TW-1:0] tmo_cnt;
  logic          tmo_evt;

  // History keeps running with EN low so a CKO already high at enable is not a new edge
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      cko_sync <= '0;
      sync_d   <= 1'b0;
    end else begin
      cko_sync <= {cko_sync[SYNC_STAGES-2:0], CKO};
      sync_d   <= cko_sync[SYNC_STAGES-1];
    end
  end

  assign edge_p = cko_sync[SYNC_STAGES-1] & ~sync_d;

  always_comb begin
    data_rev = '0;
    for (int i = 0; i < 10; i++) data_rev[9-i] = DATA[i];
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      cap_valid <= 1'b0;
      cap_data  <= '0;
    end else begin
      cap_valid <= edge_p && EN;
      if (edge_p) cap_data <= data_rev;
    end
  end

  // The first sample of a group uses the live AVG_SEL; later samples use the latched copy
  always_comb begin
    shift = (cnt == 3'd0) ? AVG_SEL : avg_lat;
    case (shift)
      2'd0:    last_cnt = 3'd0;
      2'd1:    last_cnt = 3'd1;
      2'd2:    last_cnt = 3'd3;
      default: last_cnt = 3'd7;
    endcase
    sum        = acc + 13'(cap_data);
    last       = (cnt == last_cnt);
    push       = cap_valid && EN && last;
    avg_result = 10'(sum >> shift);
  end

  always_ff @(posedge CLK) begin
    if (!RST_N || !EN) begin
      cnt     <= '0;
      acc     <= '0;
      avg_lat <= '0;
    end else if (cap_valid) begin
      if (cnt == 3'd0) avg_lat <= AVG_SEL;
      if (last) begin
        cnt <= '0;
        acc <= '0;
      end else begin
        cnt <= cnt + 3'd1;
        acc <= sum;
      end
    end
  end

  assign full    = (level == LW'(FIFO_DEPTH));
  assign do_pop  = OUT_VALID && OUT_READY;
  assign do_push = push && (!full || do_pop);
  assign ovf_evt = push && full && !do_pop;

  always_ff @(posedge CLK) begin
    if (do_push) mem[wr_ptr] <= avg_result;
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      level <= level + LW'(do_push) - LW'(do_pop);
    end
  end

  assign OUT_VALID = (level != '0);
  assign OUT_DATA  = OUT_VALID ? mem[rd_ptr] : '0;
  assign LEVEL     = level;

  // Fires once, on the increment that reaches TIMEOUT; the counter then saturates
  assign tmo_evt = EN && !edge_p && (tmo_cnt == TW'(TIMEOUT - 1));

  always_ff @(posedge CLK) begin
    if (!RST_N || !EN || edge_p) tmo_cnt <= '0;
    else if (tmo_cnt != TW'(TIMEOUT)) tmo_cnt <= tmo_cnt + TW'(1);
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      OVF <= 1'b0;
      TMO <= 1'b0;
    end else begin
      OVF <= (OVF && !CLR) || ovf_evt;
      TMO <= (TMO && !CLR) || tmo_evt;
    end
  end

endmodule

// File: tb/tb_sar10b_rx.sv
// tb/tb_sar10b_rx.sv - directed self-checking bench for sar10b_rx
module tb_sar10b_rx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       cko = 1'b0;
  logic [0:9] data = '0;
  logic [1:0] avg_sel = 2'd0;
  logic       clr = 1'b0;
  logic [9:0] out_data;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [2:0] level;
  logic       ovf;
  logic       tmo;

  int tests = 0;
  int fails = 0;

  sar10b_rx #(.SYNC_STAGES(2), .FIFO_DEPTH(4), .TIMEOUT(20)) dut (
    .CLK(clk), .RST_N(rst_n), .EN(en), .CKO(cko), .DATA(data),
    .AVG_SEL(avg_sel), .CLR(clr), .OUT_DATA(out_data), .OUT_VALID(out_valid),
    .OUT_READY(out_ready), .LEVEL(level), .OVF(ovf), .TMO(tmo)
  );

  always #5 clk = ~clk;

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // One CKO pulse: 3 cycles high, 4 low; the result is in the FIFO when this returns
  task automatic send(input logic [9:0] v);
    data = v;
    cko = 1'b1;
    cycles(3);
    cko = 1'b0;
    cycles(4);
  endtask

  task automatic pop_one;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    cycles(2);
    tests++;
    if ({out_data, out_valid, level, ovf, tmo} !== 16'h0) begin
      fails++;
      $display("FAIL reset_state: got data=%h valid=%b level=%0d ovf=%b tmo=%b, expected all 0",
               out_data, out_valid, level, ovf, tmo);
    end
    rst_n = 1'b1;
    en = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single;
    logic [3:0] vhist;
    avg_sel = 2'd0;
    data = 10'b1011001110;
    cko = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      vhist[i] = out_valid;
    end
    cko = 1'b0;
    tests++;
    if (vhist !== 4'b1000) begin
      fails++;
      $display("FAIL single_latency: valid after edges n..n+3 got %b, expected 1000 (lsb first)", vhist);
    end
    cycles(2);
    tests++;
    if (out_data !== 10'h2CE || level !== 3'd1) begin
      fails++;
      $display("FAIL single_data: got data=%h level=%0d, expected 2ce level 1", out_data, level);
    end
    pop_one();
    tests++;
    if (out_valid !== 1'b0 || level !== 3'd0) begin
      fails++;
      $display("FAIL single_pop: got valid=%b level=%0d, expected 0 0", out_valid, level);
    end
  endtask

  task automatic test_averaging;
    avg_sel = 2'd2;
    send(10'd100);
    send(10'd101);
    avg_sel = 2'd0;
    send(10'd102);
    tests++;
    if (level !== 3'd0) begin
      fails++;
      $display("FAIL avg_partial: got level=%0d after 3 samples, expected 0", level);
    end
    send(10'd104);
    tests++;
    if (level !== 3'd1 || out_data !== 10'd101) begin
      fails++;
      $display("FAIL avg_result: got level=%0d data=%0d, expected level 1 data 101", level, out_data);
    end
    pop_one();
    send(10'd7);
    tests++;
    if (level !== 3'd1 || out_data !== 10'd7) begin
      fails++;
      $display("FAIL avg_next_group: got level=%0d data=%0d, expected level 1 data 7", level, out_data);
    end
    pop_one();
  endtask

  task automatic test_overflow;
    avg_sel = 2'd0;
    out_ready = 1'b0;
    for (int v = 1; v <= 5; v++) send(10'(v));
    tests++;
    if (level !== 3'd4 || ovf !== 1'b1) begin
      fails++;
      $display("FAIL ovf_full: got level=%0d ovf=%b, expected level 4 ovf 1", level, ovf);
    end
    for (int v = 1; v <= 4; v++) begin
      tests++;
      if (out_data !== 10'(v)) begin
        fails++;
        $display("FAIL ovf_order: got %0d, expected %0d", out_data, v);
      end
      pop_one();
    end
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    tests++;
    if (ovf !== 1'b0 || level !== 3'd0) begin
      fails++;
      $display("FAIL ovf_clr: got ovf=%b level=%0d, expected 0 0", ovf, level);
    end
    for (int v = 11; v <= 14; v++) send(10'(v));
    // Raise READY for exactly the edge on which the fifth result is written
    data = 10'd15;
    cko = 1'b1;
    cycles(3);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    cko = 1'b0;
    cycles(3);
    tests++;
    if (level !== 3'd4 || ovf !== 1'b0 || out_data !== 10'd12) begin
      fails++;
      $display("FAIL ovf_push_pop: got level=%0d ovf=%b head=%0d, expected 4 0 12", level, ovf, out_data);
    end
    for (int v = 12; v <= 15; v++) begin
      tests++;
      if (out_data !== 10'(v)) begin
        fails++;
        $display("FAIL ovf_drain: got %0d, expected %0d", out_data, v);
      end
      pop_one();
    end
  endtask

  task automatic test_back_to_back;
    logic [9:0] exp_q [3];
    logic [9:0] held;
    logic       was_valid;
    logic       was_ready;
    int         idx;
    exp_q[0] = 10'h155;
    exp_q[1] = 10'h2AA;
    exp_q[2] = 10'h3FF;
    idx = 0;
    for (int i = 0; i < 3; i++) send(exp_q[i]);
    for (int c = 0; c < 10; c++) begin
      out_ready = c[0];
      held = out_data;
      was_valid = out_valid;
      was_ready = out_ready;
      @(negedge clk);
      if (was_valid && was_ready) begin
        tests++;
        if (idx > 2 || held !== exp_q[idx > 2 ? 0 : idx]) begin
          fails++;
          $display("FAIL bp_pop: got %h at index %0d", held, idx);
        end
        idx++;
      end else if (was_valid) begin
        tests++;
        if (out_data !== held || out_valid !== 1'b1) begin
          fails++;
          $display("FAIL bp_hold: got %h valid=%b, expected %h valid 1", out_data, out_valid, held);
        end
      end
    end
    out_ready = 1'b0;
    tests++;
    if (idx !== 3 || level !== 3'd0) begin
      fails++;
      $display("FAIL bp_count: got pops=%0d level=%0d, expected 3 0", idx, level);
    end
  endtask

  task automatic test_timeout_en;
    en = 1'b0;
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    en = 1'b1;
    cycles(19);
    tests++;
    if (tmo !== 1'b0) begin
      fails++;
      $display("FAIL tmo_early: got tmo=%b after 19 cycles, expected 0", tmo);
    end
    @(negedge clk);
    tests++;
    if (tmo !== 1'b1) begin
      fails++;
      $display("FAIL tmo_set: got tmo=%b after 20 cycles, expected 1", tmo);
    end
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    cycles(3);
    tests++;
    if (tmo !== 1'b0) begin
      fails++;
      $display("FAIL tmo_clr: got tmo=%b after CLR while saturated, expected 0", tmo);
    end
    en = 1'b0;
    avg_sel = 2'd0;
    send(10'd99);
    tests++;
    if (level !== 3'd0) begin
      fails++;
      $display("FAIL en_ignore: got level=%0d with EN low, expected 0", level);
    end
    en = 1'b1;
    avg_sel = 2'd1;
    send(10'd50);
    en = 1'b0;
    cycles(2);
    en = 1'b1;
    send(10'd10);
    send(10'd20);
    tests++;
    if (level !== 3'd1 || out_data !== 10'd15) begin
      fails++;
      $display("FAIL en_avg_discard: got level=%0d data=%0d, expected 1 15", level, out_data);
    end
    pop_one();
    avg_sel = 2'd0;
    en = 1'b0;
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    en = 1'b1;
    cycles(19);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    tests++;
    if (tmo !== 1'b1) begin
      fails++;
      $display("FAIL tmo_clr_coincide: got tmo=%b, expected 1", tmo);
    end
  endtask

  task automatic test_reset_midop;
    out_ready = 1'b0;
    avg_sel = 2'd0;
    for (int v = 1; v <= 3; v++) send(10'(v + 40));
    cycles(20);
    tests++;
    if (level !== 3'd3 || tmo !== 1'b1) begin
      fails++;
      $display("FAIL midop_setup: got level=%0d tmo=%b, expected 3 1", level, tmo);
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tests++;
    if ({out_data, out_valid, level, ovf, tmo} !== 16'h0) begin
      fails++;
      $display("FAIL midop_reset: got data=%h valid=%b level=%0d ovf=%b tmo=%b, expected all 0",
               out_data, out_valid, level, ovf, tmo);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_averaging();
    test_overflow();
    test_back_to_back();
    test_timeout_en();
    test_reset_midop();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
